// File: rtl/vga_timing_decoder_if.sv
// vga_timing_decoder_if
// Bundles the sync pair arriving from the VGA connector side together with
// the timing information recovered from it.
//   master : drives pix_en/hs_in/vs_in, observes the recovered timing
//   slave  : the decoder; samples the sync pair, drives x/y/de/pulses/status
// Signals:
//   pix_en       one-clk pixel strobe
//   hs_in/vs_in  active-low horizontal/vertical sync
//   x, y         active-region column/row, 0 outside the visible area
//   de           visible-area pixel
//   line_start   one-clk pulse on a recognised HS falling edge
//   frame_start  one-clk pulse on a recognised VS falling edge
//   locked       incoming timing matches the configured geometry
//   timing_err   sticky flag, set whenever lock is lost
interface vga_timing_decoder_if;
  logic       pix_en;
  logic       hs_in;
  logic       vs_in;
  logic [9:0] x;
  logic [9:0] y;
  logic       de;
  logic       line_start;
  logic       frame_start;
  logic       locked;
  logic       timing_err;

  modport master (
    output pix_en, hs_in, vs_in,
    input  x, y, de, line_start, frame_start, locked, timing_err
  );

  modport slave (
    input  pix_en, hs_in, vs_in,
    output x, y, de, line_start, frame_start, locked, timing_err
  );
endinterface

// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder
// Receive side of the VGA sync pair. Rebuilds pixel/line counters purely from
// HS/VS falling edges, checks line and frame lengths against the configured
// geometry, and reports lock, visible-area position and data enable.
// Ports:
//   clk    system clock (all state advances only on vif.pix_en)
//   reset  synchronous, active-high
//   vif    vga_timing_decoder_if.slave (sync inputs, recovered timing outputs)
// Build option:
//   VGA_SYNC_GLITCH_FILTER_EN  when defined, a sync edge needs two consecutive
//                              low samples after a high; one-sample low
//                              glitches are ignored. Undefined: plain edges.
module vga_timing_decoder #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 521
) (
  input logic                 clk,
  input logic                 reset,
  vga_timing_decoder_if.slave vif
);

`ifdef VGA_SYNC_GLITCH_FILTER_EN
  // A filtered edge is seen one pixel late, so hcnt restarts at 1 to keep
  // the visible window where it would be without the filter.
  localparam int EDGE_DELAY = 1;
`else
  localparam int EDGE_DELAY = 0;
`endif

  localparam logic [9:0]  EDGE_LOAD = 10'(EDGE_DELAY);
  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1 + EDGE_DELAY);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_FIRST   = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END     = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_FIRST   = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_END     = 11'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [9:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt, h_inc, v_inc;
  logic       prev_hs, prev_vs;
  logic       frame_bad;
  logic       hs_edge, vs_edge, bad_line, good_frame;
  logic       err_nxt, de_nxt;
  logic [9:0] x_nxt, y_nxt;
  logic [9:0] x_q, y_q;
  logic       de_q, ls_q, fs_q, locked_q, err_q;

`ifdef VGA_SYNC_GLITCH_FILTER_EN
  logic prev2_hs, prev2_vs;

  // Second history stage for the debounce: high, low, low marks an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev2_hs <= 1'b1;
      prev2_vs <= 1'b1;
    end else if (vif.pix_en) begin
      prev2_hs <= prev_hs;
      prev2_vs <= prev_vs;
    end
  end

  assign hs_edge = prev2_hs & ~prev_hs & ~vif.hs_in;
  assign vs_edge = prev2_vs & ~prev_vs & ~vif.vs_in;
`else
  assign hs_edge = prev_hs & ~vif.hs_in;
  assign vs_edge = prev_vs & ~vif.vs_in;
`endif

  // Next-state view of the counters, checks and lock FSM. The visible
  // window and x/y are derived from the next counter values so that de/x/y
  // line up with hcnt/vcnt without an extra pixel of latency.
  always_comb begin
    h_inc      = (hcnt == 10'h3ff) ? hcnt : hcnt + 10'd1;
    v_inc      = (vcnt == 10'h3ff) ? vcnt : vcnt + 10'd1;
    bad_line   = hs_edge & ({1'b0, hcnt} != H_LAST);
    // A bad line ending on the VS edge itself still belongs to the old frame.
    good_frame = ~frame_bad & ~bad_line & ({1'b0, vcnt} == V_LAST);
    hcnt_nxt   = hs_edge ? EDGE_LOAD : h_inc;
    // The debounced VS edge is seen on the same pixel as the debounced HS
    // edge, so the line counter needs no offset and always restarts at 0.
    vcnt_nxt   = vs_edge ? 10'd0 : (hs_edge ? v_inc : vcnt);

    state_nxt = state;
    err_nxt   = err_q;
    case (state)
      UNLOCKED: if (vs_edge) state_nxt = ACQUIRE;
      ACQUIRE:  if (vs_edge && good_frame) state_nxt = LOCKED;
      LOCKED: begin
        if (bad_line || (vs_edge && !good_frame)) begin
          state_nxt = UNLOCKED;
          err_nxt   = 1'b1;
        end
      end
      default:  state_nxt = UNLOCKED;
    endcase

    de_nxt = (state_nxt == LOCKED)
           && ({1'b0, hcnt_nxt} >= H_FIRST) && ({1'b0, hcnt_nxt} < H_END)
           && ({1'b0, vcnt_nxt} >= V_FIRST) && ({1'b0, vcnt_nxt} < V_END);
    x_nxt  = de_nxt ? hcnt_nxt - H_FIRST[9:0] : 10'd0;
    y_nxt  = de_nxt ? vcnt_nxt - V_FIRST[9:0] : 10'd0;
  end

  // All tracking state and registered outputs. The start pulses are cleared
  // on every clock so they last exactly one clk after the detecting strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= UNLOCKED;
      hcnt      <= 10'd0;
      vcnt      <= 10'd0;
      prev_hs   <= 1'b1;
      prev_vs   <= 1'b1;
      frame_bad <= 1'b0;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      de_q      <= 1'b0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      if (vif.pix_en) begin
        prev_hs   <= vif.hs_in;
        prev_vs   <= vif.vs_in;
        hcnt      <= hcnt_nxt;
        vcnt      <= vcnt_nxt;
        state     <= state_nxt;
        frame_bad <= vs_edge ? 1'b0 : (frame_bad | bad_line);
        ls_q      <= hs_edge;
        fs_q      <= vs_edge;
        locked_q  <= (state_nxt == LOCKED);
        err_q     <= err_nxt;
        de_q      <= de_nxt;
        x_q       <= x_nxt;
        y_q       <= y_nxt;
      end
    end
  end

  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.de          = de_q;
  assign vif.line_start  = ls_q;
  assign vif.frame_start = fs_q;
  assign vif.locked      = locked_q;
  assign vif.timing_err  = err_q;

endmodule
